// File: rtl/rapids_pkg.sv
// Shared fetch-stage types: FSM state encoding, buffer entry layout and the
// legal-address helper used by the fetch stage.
package rapids_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FETCH   = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;
   localparam logic [1:0] ST_FAULTED = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      FETCH   = ST_FETCH,
      DISCARD = ST_DISCARD,
      FAULTED = ST_FAULTED
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] word;
      logic               fault;
   } fetch_entry_t;

   function automatic logic addr_legal(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
      return (addr[1:0] == 2'b00) && (addr >= base) && (addr < limit);
   endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Two-entry in-order prefetch FIFO of {word, fault}; flush may coincide with a
// push, in which case the pushed entry becomes the sole content.
module prefetch_buffer
   import rapids_pkg::*;
(
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         push_i,
   input  fetch_entry_t push_entry_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);

   fetch_entry_t [1:0] entry_q, entry_d;
   logic [1:0]         count_q, count_d;
   logic               pop_s;

   // Next-state for entries and occupancy.
   always_comb begin
      entry_d = entry_q;
      count_d = count_q;
      pop_s   = pop_i && (count_q != 2'd0);
      if (flush_i) begin
         if (push_i) begin
            entry_d[0] = push_entry_i;
            count_d    = 2'd1;
         end else begin
            count_d = 2'd0;
         end
      end else begin
         case ({push_i, pop_s})
            2'b10: begin
               if (count_q == 2'd0) begin
                  entry_d[0] = push_entry_i;
                  count_d    = 2'd1;
               end else if (count_q == 2'd1) begin
                  entry_d[1] = push_entry_i;
                  count_d    = 2'd2;
               end else begin
                  count_d = count_q;
               end
            end
            2'b01: begin
               entry_d[0] = entry_q[1];
               count_d    = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  entry_d[0] = push_entry_i;
               end else begin
                  entry_d[0] = entry_q[1];
                  entry_d[1] = push_entry_i;
               end
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
   end

   // Entry and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         entry_q <= '0;
         count_q <= 2'd0;
      end else begin
         entry_q <= entry_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = entry_q[0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns pc/fetch_pc, issues single-outstanding word reads and
// feeds the prefetch buffer; head outputs decode from registers only.
module instruction_fetch
   import rapids_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] SEG_BASE  = 32'h0000_0000,
   parameter logic [31:0] SEG_LIMIT = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_inc,
   input  logic        pc_load,
   input  logic [31:0] pc_target,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        wait_instr,
   output logic        instr_segv,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        imem_fault
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic         run_q;

   logic         fetch_legal_s, room_s, issue_s, req_s, outstanding_s;
   logic         push_s, pop_s, flush_s;
   fetch_entry_t push_entry_s, head_s;
   logic [1:0]   count_s;

   prefetch_buffer u_buf (
      .clk_i        (clk),
      .reset_i      (reset),
      .push_i       (push_s),
      .push_entry_i (push_entry_s),
      .pop_i        (pop_s),
      .flush_i      (flush_s),
      .count_o      (count_s),
      .head_o       (head_s)
   );

   // Request issue: IDLE presents the request in the same cycle it decides to
   // fetch, so a zero-wait memory can sustain one word per cycle.
   always_comb begin
      fetch_legal_s = addr_legal(fetch_pc_q, SEG_BASE, SEG_LIMIT);
      room_s        = (count_s < 2'd2);
      issue_s       = run_q && (state_q == IDLE) && room_s && fetch_legal_s;
      req_s         = issue_s || (state_q == FETCH) || (state_q == DISCARD);
      outstanding_s = req_s && !imem_ack;
   end

   // FSM next state, PC updates and buffer control.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_pc_d   = fetch_pc_q;
      push_s       = 1'b0;
      push_entry_s = '0;
      pop_s        = 1'b0;
      flush_s      = 1'b0;
      if (issue_s) begin
         req_addr_d = fetch_pc_q;
      end else begin
         req_addr_d = req_addr_q;
      end
      if (pc_load) begin
         flush_s    = 1'b1;
         pc_d       = pc_target;
         fetch_pc_d = pc_target;
         if (outstanding_s) begin
            state_d = DISCARD;
         end else if (!addr_legal(pc_target, SEG_BASE, SEG_LIMIT)) begin
            push_s             = 1'b1;
            push_entry_s.fault = 1'b1;
            state_d            = FAULTED;
         end else begin
            state_d = IDLE;
         end
      end else begin
         pop_s = pc_inc && (count_s != 2'd0) && !head_s.fault;
         if (pop_s) begin
            pc_d = pc_q + PC_STEP;
         end else begin
            pc_d = pc_q;
         end
         case (state_q)
            IDLE, FETCH: begin
               if (req_s && imem_ack) begin
                  push_s            = 1'b1;
                  push_entry_s.word = imem_rdata;
                  push_entry_s.fault = imem_fault;
                  fetch_pc_d        = fetch_pc_q + PC_STEP;
                  state_d           = imem_fault ? FAULTED : IDLE;
               end else if (req_s) begin
                  state_d = FETCH;
               end else if (run_q && room_s && !fetch_legal_s) begin
                  // Illegal address: the fault stands in for the word.
                  push_s             = 1'b1;
                  push_entry_s.fault = 1'b1;
                  state_d            = FAULTED;
               end else begin
                  state_d = IDLE;
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  state_d = IDLE;
               end else begin
                  state_d = DISCARD;
               end
            end
            FAULTED: begin
               state_d = FAULTED;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         run_q      <= 1'b1;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      imem_req    = req_s;
      pc          = pc_q;
      wait_instr  = (count_s == 2'd0);
      instr_segv  = (count_s != 2'd0) && head_s.fault;
      if ((state_q == FETCH) || (state_q == DISCARD)) begin
         imem_addr = req_addr_q;
      end else begin
         imem_addr = fetch_pc_q;
      end
      if ((count_s != 2'd0) && !head_s.fault) begin
         instruction = head_s.word;
      end else begin
         instruction = '0;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plus randomized bench for instruction_fetch against a memory that
// returns addr ^ 32'hA5A5_0000 and an address-stream reference model.
module tb_instruction_fetch;

   localparam logic [31:0] SEG_LIMIT = 32'h0001_0000;
   localparam logic [31:0] KEY       = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_inc = 1'b0;
   logic        pc_load = 1'b0;
   logic [31:0] pc_target = 32'h0;
   logic [31:0] instruction, pc, imem_addr;
   logic        wait_instr, instr_segv, imem_req;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_fault = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          mem_wait = 0;
   bit          mem_rand = 1'b0;
   bit          fault_en = 1'b0;
   logic [31:0] fault_addr = 32'h0;

   instruction_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .pc_target   (pc_target),
      .instruction (instruction),
      .pc          (pc),
      .wait_instr  (wait_instr),
      .instr_segv  (instr_segv),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .imem_fault  (imem_fault)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Memory responder: acks after cur_wait cycles of a held request.
   initial begin
      int wcnt;
      int cur_wait;
      wcnt = 0;
      cur_wait = 0;
      forever begin
         @(negedge clk);
         if (imem_req) begin
            if (wcnt >= cur_wait) begin
               imem_ack   = 1'b1;
               imem_rdata = imem_addr ^ KEY;
               imem_fault = fault_en && (imem_addr == fault_addr);
               wcnt       = 0;
               cur_wait   = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
            end else begin
               imem_ack   = 1'b0;
               imem_fault = 1'b0;
               wcnt++;
            end
         end else begin
            imem_ack   = 1'b0;
            imem_fault = 1'b0;
            wcnt       = 0;
            cur_wait   = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string t);
      check({t, "_instr"}, instruction, 32'h0);
      check({t, "_pc"}, pc, 32'h0);
      check_b({t, "_wait"}, wait_instr, 1'b1);
      check_b({t, "_segv"}, instr_segv, 1'b0);
      check_b({t, "_req"}, imem_req, 1'b0);
      check({t, "_addr"}, imem_addr, 32'h0);
   endtask

   // Leaves the bench in cycle 0 (reset just released, not yet sampled).
   task automatic do_reset();
      reset   = 1'b1;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      repeat (2) step();
      check_reset_outputs("reset");
      reset = 1'b0;
   endtask

   task automatic wait_req_addr(input logic [31:0] a, input string tag);
      int k;
      k = 0;
      while (!(imem_req === 1'b1 && imem_addr === a) && k < 40) begin
         step();
         k++;
      end
      check_b(tag, k < 40, 1'b1);
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] prev_addr;
      logic        prev_pend;
      int          k;

      // Zero-wait streaming with pc_inc held high.
      mem_wait = 0;
      do_reset();
      pc_inc = 1'b1;
      step();
      check_b("c1_req", imem_req, 1'b1);
      check("c1_addr", imem_addr, 32'h0);
      check_b("c1_wait", wait_instr, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stream_instr", instruction, KEY | (32'd4 * i));
         check("stream_pc", pc, 32'd4 * i);
         check_b("stream_wait", wait_instr, 1'b0);
      end

      // Three wait states, no consumption.
      mem_wait = 3;
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         step();
         check_b("ws_req", imem_req, 1'b1);
         check("ws_addr", imem_addr, 32'h0);
         check_b("ws_wait", wait_instr, 1'b1);
      end
      step();
      check_b("ws_wait_after", wait_instr, 1'b0);
      check("ws_instr", instruction, KEY);
      for (int c = 6; c <= 12; c++) begin
         step();
         if (c >= 9) check_b("ws_full_noreq", imem_req, 1'b0);
      end

      // Redirect while the request for 0x8 is outstanding.
      pc_inc = 1'b1;
      step();
      pc_inc = 1'b0;
      wait_req_addr(32'h8, "rd_req8_seen");
      pc_load   = 1'b1;
      pc_target = 32'h100;
      step();
      pc_load = 1'b0;
      check("rd_pc", pc, 32'h100);
      check_b("rd_wait", wait_instr, 1'b1);
      wait_req_addr(32'h100, "rd_req100_seen");
      check_b("rd_still_empty", wait_instr, 1'b1);
      k = 0;
      while (wait_instr === 1'b1 && k < 40) begin
         step();
         k++;
      end
      check("rd_instr", instruction, KEY ^ 32'h100);
      check("rd_pc_after", pc, 32'h100);

      // Misaligned and out-of-segment redirects.
      mem_wait = 0;
      k = 0;
      while (imem_req !== 1'b0 && k < 40) begin
         step();
         k++;
      end
      pc_load   = 1'b1;
      pc_target = 32'h102;
      step();
      pc_load = 1'b0;
      pc_inc  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_b("mis_req", imem_req, 1'b0);
         check_b("mis_segv", instr_segv, 1'b1);
         check_b("mis_wait", wait_instr, 1'b0);
         check("mis_instr", instruction, 32'h0);
         check("mis_pc", pc, 32'h102);
         step();
      end
      pc_load   = 1'b1;
      pc_target = SEG_LIMIT;
      step();
      pc_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_b("lim_req", imem_req, 1'b0);
         check_b("lim_segv", instr_segv, 1'b1);
         check_b("lim_wait", wait_instr, 1'b0);
         check("lim_pc", pc, SEG_LIMIT);
         step();
      end
      pc_inc    = 1'b0;
      pc_load   = 1'b1;
      pc_target = 32'h200;
      step();
      pc_load = 1'b0;
      check_b("recover_segv", instr_segv, 1'b0);
      check_b("recover_req", imem_req, 1'b1);
      check("recover_addr", imem_addr, 32'h200);

      // Bus fault on 0x4.
      fault_en   = 1'b1;
      fault_addr = 32'h4;
      do_reset();
      pc_inc = 1'b1;
      step();
      step();
      check("flt_first_instr", instruction, KEY);
      check_b("flt_first_segv", instr_segv, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_b("flt_segv", instr_segv, 1'b1);
         check_b("flt_wait", wait_instr, 1'b0);
         check("flt_instr", instruction, 32'h0);
         check("flt_pc", pc, 32'h4);
         check_b("flt_noreq", imem_req, 1'b0);
      end

      // Reset while FAULTED.
      fault_en = 1'b0;
      reset    = 1'b1;
      pc_inc   = 1'b0;
      step();
      check_reset_outputs("rst_faulted");
      reset = 1'b0;
      step();
      check_b("rst_faulted_restart_req", imem_req, 1'b1);
      check("rst_faulted_restart_addr", imem_addr, 32'h0);

      // Reset while a request waits in FETCH.
      mem_wait = 3;
      do_reset();
      step();
      step();
      check_b("fetch_pending", imem_req, 1'b1);
      reset = 1'b1;
      step();
      check_reset_outputs("rst_fetch");
      reset = 1'b0;
      step();
      check_b("rst_fetch_restart_req", imem_req, 1'b1);
      check("rst_fetch_restart_addr", imem_addr, 32'h0);

      // Randomized traffic against the address-stream model.
      mem_rand = 1'b1;
      do_reset();
      exp_pc    = 32'h0;
      prev_pend = 1'b0;
      prev_addr = 32'h0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         check("rnd_pc", pc, exp_pc);
         if (wait_instr === 1'b0) begin
            check_b("rnd_segv", instr_segv, exp_pc >= SEG_LIMIT);
            check("rnd_instr", instruction, (exp_pc >= SEG_LIMIT) ? 32'h0 : (exp_pc ^ KEY));
         end
         if (imem_req === 1'b1) begin
            check_b("rnd_addr_legal", (imem_addr[1:0] == 2'b00) && (imem_addr < SEG_LIMIT), 1'b1);
         end
         if (prev_pend) begin
            check_b("rnd_req_held", imem_req, 1'b1);
            check("rnd_addr_held", imem_addr, prev_addr);
         end
         pc_inc    = 1'($urandom_range(0, 1));
         pc_load   = ($urandom_range(0, 15) == 0);
         pc_target = 32'($urandom_range(0, 32'h3FFF)) << 2;
         if (pc_load) begin
            exp_pc = pc_target;
         end else if (pc_inc && !wait_instr && exp_pc < SEG_LIMIT) begin
            exp_pc = exp_pc + 32'd4;
         end
         prev_pend = imem_req && !imem_ack;
         prev_addr = imem_addr;
         step();
      end
      pc_inc  = 1'b0;
      pc_load = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
